// File: rtl/apb_cmd_master.sv
// apb_cmd_master
//   APB initiator that converts a valid/ready command stream into APB
//   SETUP/ACCESS transfers and returns exactly one response per command.
//   It holds up to two pending commands in a FIFO and has one transfer in
//   flight. A transfer whose completer never raises PREADY is aborted after
//   TIMEOUT_CYCLES ACCESS cycles (0 disables the timeout).
//
// Ports
//   HCLK, HRESETn       clock, synchronous active-low reset
//   cmd_*               command input (valid/ready, write, addr, wdata)
//   rsp_*               response output (valid/ready, rdata, err, timeout)
//   PADDR..PENABLE      APB request outputs
//   PRDATA/PREADY/PSLVERR APB completer inputs
//   busy_o              command pending or transfer/response in progress
module apb_cmd_master #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]               cmd_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic                      busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  localparam bit          LP_TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                    r_state;
  logic [15:0]               r_acc_cnt;

  // Two-entry command FIFO
  logic                      r_fifo_write [2];
  logic [APB_ADDR_WIDTH-1:0] r_fifo_addr  [2];
  logic [31:0]               r_fifo_wdata [2];
  logic                      r_wr_ptr;
  logic                      r_rd_ptr;
  logic [1:0]                r_count;

  logic                      r_psel;
  logic                      r_penable;
  logic                      r_pwrite;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [31:0]               r_pwdata;
  logic                      r_rsp_valid;
  logic [31:0]               r_rsp_rdata;
  logic                      r_rsp_err;
  logic                      r_rsp_timeout;

  logic                      w_full;
  logic                      w_push;
  logic                      w_pop;

  // Full is evaluated on registered occupancy, so a pop in the same cycle
  // never opens room for a push.
  assign w_full = (r_count == 2'd2);
  assign w_push = cmd_valid_i && !w_full;
  assign w_pop  = (r_count != 2'd0) &&
                  ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready_i));

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_fifo_write[i] <= 1'b0;
        r_fifo_addr[i]  <= '0;
        r_fifo_wdata[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo_write[r_wr_ptr] <= cmd_write_i;
        r_fifo_addr[r_wr_ptr]  <= cmd_addr_i;
        r_fifo_wdata[r_wr_ptr] <= cmd_wdata_i;
        r_wr_ptr               <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state       <= S_IDLE;
      r_acc_cnt     <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_paddr  <= r_fifo_addr[r_rd_ptr];
            r_pwdata <= r_fifo_wdata[r_rd_ptr];
            r_pwrite <= r_fifo_write[r_rd_ptr];
            r_psel   <= 1'b1;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_acc_cnt <= '0;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // PREADY is tested first so completion on the last permitted
          // cycle takes priority over the timeout abort.
          if (PREADY) begin
            r_rsp_rdata   <= r_pwrite ? '0 : PRDATA;
            r_rsp_err     <= PSLVERR;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= S_RESP;
          end else if (LP_TO_EN && (r_acc_cnt == LP_TO_LAST)) begin
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= S_RESP;
          end else begin
            r_acc_cnt <= r_acc_cnt + 16'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            if (w_pop) begin
              r_paddr  <= r_fifo_addr[r_rd_ptr];
              r_pwdata <= r_fifo_wdata[r_rd_ptr];
              r_pwrite <= r_fifo_write[r_rd_ptr];
              r_psel   <= 1'b1;
              r_state  <= S_SETUP;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = !w_full;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_err_o     = r_rsp_err;
  assign rsp_timeout_o = r_rsp_timeout;
  assign PADDR         = r_paddr;
  assign PWDATA        = r_pwdata;
  assign PWRITE        = r_pwrite;
  assign PSEL          = r_psel;
  assign PENABLE       = r_penable;
  assign busy_o        = (r_count != 2'd0) || (r_state != S_IDLE);

endmodule

// File: tb/tb_apb_cmd_master.sv
module tb_apb_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [11:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  apb_cmd_master #(
    .APB_ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .busy_o(busy_o)
  );

  always #5 HCLK = ~HCLK;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic w, input logic [11:0] a, input logic [31:0] d);
    cmd_valid_i = 1'b1;
    cmd_write_i = w;
    cmd_addr_i  = a;
    cmd_wdata_i = d;
  endtask

  task automatic send(input logic w, input logic [11:0] a, input logic [31:0] d);
    present(w, a, d);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    HRESETn = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
    cmd_wdata_i = '0; rsp_ready_i = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_psel",      32'(PSEL),        32'd0);
    chk("rst_penable",   32'(PENABLE),     32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_busy",      32'(busy_o),      32'd0);
    chk("rst_paddr",     32'(PADDR),       32'd0);
    HRESETn = 1'b1;
    tick();

    // Write 0x000 <- 0xFFFFFFF1, PREADY tied high
    PREADY = 1'b1;
    send(1'b1, 12'h000, 32'hFFFF_FFF1);
    chk("w1_psel_k",     32'(PSEL),        32'd0);
    chk("w1_busy_k",     32'(busy_o),      32'd1);
    tick();
    chk("w1_psel_k1",    32'(PSEL),        32'd1);
    chk("w1_pen_k1",     32'(PENABLE),     32'd0);
    chk("w1_pwrite",     32'(PWRITE),      32'd1);
    chk("w1_pwdata",     PWDATA,           32'hFFFF_FFF1);
    tick();
    chk("w1_pen_k2",     32'(PENABLE),     32'd1);
    tick();
    chk("w1_psel_drop",  32'(PSEL),        32'd0);
    chk("w1_rsp_valid",  32'(rsp_valid_o), 32'd1);
    chk("w1_rsp_err",    32'(rsp_err_o),   32'd0);
    chk("w1_rsp_rdata",  rsp_rdata_o,      32'd0);
    handshake();
    chk("w1_rsp_done",   32'(rsp_valid_o), 32'd0);
    chk("w1_busy_done",  32'(busy_o),      32'd0);

    // Read 0x004, three wait cycles, data on the 4th ACCESS cycle
    PREADY = 1'b0; PRDATA = 32'hDEAD_0000;
    send(1'b0, 12'h004, 32'h0);
    tick();
    chk("r2_setup_addr", 32'(PADDR),       32'h004);
    chk("r2_pwrite",     32'(PWRITE),      32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("r2_wait_pen",  32'(PENABLE), 32'd1);
      chk("r2_wait_addr", 32'(PADDR),   32'h004);
      tick();
    end
    chk("r2_last_pen",   32'(PENABLE),     32'd1);
    PREADY = 1'b1; PRDATA = 32'h0000_ABCD;
    tick();
    PREADY = 1'b0; PRDATA = 32'h0;
    chk("r2_psel_drop",  32'(PSEL),        32'd0);
    chk("r2_rsp_valid",  32'(rsp_valid_o), 32'd1);
    chk("r2_rdata",      rsp_rdata_o,      32'h0000_ABCD);
    chk("r2_timeout",    32'(rsp_timeout_o), 32'd0);
    handshake();

    // Timeout: PREADY stuck low, read data must come back as 0
    PRDATA = 32'h1234_5678;
    send(1'b0, 12'h020, 32'h0);
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_access_pen", 32'(PENABLE), 32'd1);
    end
    tick();
    chk("to_psel_drop",  32'(PSEL),          32'd0);
    chk("to_rsp_valid",  32'(rsp_valid_o),   32'd1);
    chk("to_err",        32'(rsp_err_o),     32'd1);
    chk("to_timeout",    32'(rsp_timeout_o), 32'd1);
    chk("to_rdata",      rsp_rdata_o,        32'd0);
    tick();
    chk("to_rsp_hold",   32'(rsp_valid_o),   32'd1);
    handshake();

    // PREADY on the final permitted ACCESS cycle: completion wins
    PRDATA = 32'h5A5A_5A5A;
    send(1'b1, 12'h030, 32'h0000_0077);
    tick(); tick(); tick(); tick(); tick();
    chk("edge_pen",      32'(PENABLE),       32'd1);
    PREADY = 1'b1;
    tick();
    PREADY = 1'b0;
    chk("edge_valid",    32'(rsp_valid_o),   32'd1);
    chk("edge_timeout",  32'(rsp_timeout_o), 32'd0);
    chk("edge_err",      32'(rsp_err_o),     32'd0);
    chk("edge_rdata",    rsp_rdata_o,        32'd0);
    handshake();

    // PSLVERR on a read of 0xFFC
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hCAFE_0001;
    send(1'b0, 12'hFFC, 32'h0);
    tick();
    chk("slv_addr",      32'(PADDR),         32'hFFC);
    tick(); tick();
    PSLVERR = 1'b0;
    chk("slv_valid",     32'(rsp_valid_o),   32'd1);
    chk("slv_err",       32'(rsp_err_o),     32'd1);
    chk("slv_timeout",   32'(rsp_timeout_o), 32'd0);
    chk("slv_rdata",     rsp_rdata_o,        32'hCAFE_0001);
    handshake();

    // Back-to-back: A,B,C,D offered with rsp_ready low. A goes straight to
    // SETUP, B and C fill the FIFO, D waits until the first handshake.
    PRDATA = 32'h0000_B0B0;
    present(1'b1, 12'h100, 32'd1);
    tick();
    chk("b2b_ready_a",   32'(cmd_ready_o),   32'd1);
    present(1'b0, 12'h104, 32'd0);
    tick();
    chk("b2b_a_paddr",   32'(PADDR),         32'h100);
    chk("b2b_ready_b",   32'(cmd_ready_o),   32'd1);
    present(1'b1, 12'h108, 32'd3);
    tick();
    chk("b2b_full",      32'(cmd_ready_o),   32'd0);
    present(1'b0, 12'h10C, 32'd0);
    tick();
    chk("b2b_a_valid",   32'(rsp_valid_o),   32'd1);
    chk("b2b_a_rdata",   rsp_rdata_o,        32'd0);
    tick();
    chk("b2b_d_blocked", 32'(cmd_ready_o),   32'd0);
    chk("b2b_a_hold",    32'(rsp_valid_o),   32'd1);
    handshake();
    chk("b2b_b_paddr",   32'(PADDR),         32'h104);
    chk("b2b_b_psel",    32'(PSEL),          32'd1);
    chk("b2b_ready_d",   32'(cmd_ready_o),   32'd1);
    tick();
    cmd_valid_i = 1'b0;
    chk("b2b_d_taken",   32'(cmd_ready_o),   32'd0);
    tick();
    chk("b2b_b_valid",   32'(rsp_valid_o),   32'd1);
    chk("b2b_b_rdata",   rsp_rdata_o,        32'h0000_B0B0);
    handshake();
    chk("b2b_c_paddr",   32'(PADDR),         32'h108);
    tick(); tick();
    chk("b2b_c_valid",   32'(rsp_valid_o),   32'd1);
    chk("b2b_c_pwdata",  PWDATA,             32'd3);
    chk("b2b_c_rdata",   rsp_rdata_o,        32'd0);
    handshake();
    chk("b2b_d_paddr",   32'(PADDR),         32'h10C);
    tick(); tick();
    chk("b2b_d_rdata",   rsp_rdata_o,        32'h0000_B0B0);
    handshake();
    chk("b2b_idle",      32'(busy_o),        32'd0);

    // Reset during ACCESS with one command queued
    PREADY = 1'b0;
    send(1'b0, 12'h200, 32'h0);
    present(1'b1, 12'h204, 32'h0000_0099);
    tick();
    cmd_valid_i = 1'b0;
    tick();
    chk("rst_mid_pen",   32'(PENABLE),       32'd1);
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    chk("rstm_psel",     32'(PSEL),          32'd0);
    chk("rstm_penable",  32'(PENABLE),       32'd0);
    chk("rstm_busy",     32'(busy_o),        32'd0);
    chk("rstm_valid",    32'(rsp_valid_o),   32'd0);
    chk("rstm_paddr",    32'(PADDR),         32'd0);
    chk("rstm_ready",    32'(cmd_ready_o),   32'd1);
    PREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstm_no_psel",  32'(PSEL),        32'd0);
      chk("rstm_no_rsp",   32'(rsp_valid_o), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
